// File: rtl/led_pattern_driver.sv
// led_pattern_driver: renders a buffered LED pattern as static, blink, chase or PWM dim
module led_pattern_driver #(
  parameter int LED_COUNT   = 5,
  parameter int TICK_DIV    = 50000,
  parameter int BLINK_TICKS = 250,
  parameter int CHASE_TICKS = 100,
  parameter int PWM_BITS    = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [LED_COUNT-1:0] pattern,
  input  logic [1:0]           mode,
  input  logic [PWM_BITS-1:0]  duty,
  output logic [LED_COUNT-1:0] leds,
  output logic                 tick,
  output logic                 changed
);
  localparam int PW   = $clog2(TICK_DIV);
  localparam int PMAX = BLINK_TICKS > CHASE_TICKS ? BLINK_TICKS : CHASE_TICKS;
  localparam int CW   = PMAX > 1 ? $clog2(PMAX) : 1;
  typedef enum logic [1:0] {STATIC, BLINK, CHASE, PWM} mode_t;
  logic [LED_COUNT-1:0] pattern_q, act_pat, rot, rot_left;
  mode_t                mode_q, act_mode;
  logic [PWM_BITS-1:0]  duty_q, duty_act, pwm_cnt;
  logic [PW-1:0]        presc;
  logic [CW-1:0]        phase_cnt, term;
  logic                 blink_on, wrap, load, entry;
  // next-state decisions shared by the register block
  always_comb begin
    term     = act_mode == BLINK ? CW'(BLINK_TICKS - 1) : CW'(CHASE_TICKS - 1);
    wrap     = phase_cnt == term;
    load     = tick && (pattern_q != act_pat || mode_q != act_mode);
    entry    = tick && mode_q != act_mode;
    rot_left = {rot[LED_COUNT-2:0], rot[LED_COUNT-1]};
  end
  // input stage, prescaler, apply logic, phase counters and registered LED drive
  always_ff @(posedge clk) begin
    if (reset) begin
      pattern_q <= '0;
      mode_q    <= STATIC;
      duty_q    <= '0;
      presc     <= '0;
      tick      <= 1'b0;
      changed   <= 1'b0;
      act_pat   <= '0;
      act_mode  <= STATIC;
      rot       <= '0;
      phase_cnt <= '0;
      blink_on  <= 1'b1;
      pwm_cnt   <= '0;
      duty_act  <= '0;
      leds      <= '0;
    end else begin
      pattern_q <= pattern;
      mode_q    <= mode_t'(mode);
      duty_q    <= duty;
      presc     <= presc == PW'(TICK_DIV - 1) ? '0 : presc + 1'b1;
      tick      <= presc == PW'(TICK_DIV - 2);
      changed   <= load;
      pwm_cnt   <= pwm_cnt + 1'b1;
      if (&pwm_cnt) duty_act <= duty_q;
      if (load) begin
        act_pat  <= pattern_q;
        act_mode <= mode_q;
        rot      <= pattern_q;
      end
      if (entry) begin
        phase_cnt <= '0;
        blink_on  <= 1'b1;
      end else if (tick && (act_mode == BLINK || act_mode == CHASE)) begin
        phase_cnt <= wrap ? '0 : phase_cnt + 1'b1;
        if (wrap && act_mode == BLINK) blink_on <= !blink_on;
        if (wrap && act_mode == CHASE && !load) rot <= rot_left;
      end
      leds <= act_mode == STATIC ? act_pat :
              act_mode == BLINK  ? (blink_on ? act_pat : '0) :
              act_mode == CHASE  ? rot :
              act_pat & {LED_COUNT{pwm_cnt < duty_act}};
    end
  end
endmodule
